// File: rtl/project_types.sv
// Shared types and constants for the register-write arbitration slice.
package project_types;

   localparam int DEFAULT_DEPTH        = 2;
   localparam int DEFAULT_STARVE_LIMIT = 4;

   localparam logic REG_ENABLE = 1'b1;

   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE  = 1'b0;
   localparam reset_status_t RST_DISABLE = 1'b1;

   // Full register write: enable, destination, data.
   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } reg_t;

   // Register reference without data (reads, reservations).
   typedef struct packed {
      logic       en;
      logic [4:0] addr;
   } reg_info_t;

endpackage

// File: rtl/regwrite_fifo.sv
// FIFO holding multi-cycle results until the regfile write port is free.
// Pointers carry one extra bit so full and empty are distinguishable.
module regwrite_fifo
   import project_types::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic          clk,
   input  reset_status_t rst,
   input  logic          push,
   input  reg_t          push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output reg_t          head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   reg_t        mem [DEPTH];

   // Pointer update; push is never asserted while full, pop never while empty.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst == RST_ENABLE) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; contents are only visible when empty is low, and the pointers are reset.
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the single regfile write port between the pipeline writeback and
// buffered multi-cycle results, tracks destination reservations and stalls
// decode on hazards or when a buffered result has waited too long.
// Optional: define REGWRITE_BYPASS_EN to drop the stall on a read of the
// register being written from the buffer head this cycle.
module regwrite_arbiter
   import project_types::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic          clk,
   input  reset_status_t rst,
   input  reg_t          pipe_wreg_i,
   input  reg_t          mdu_wreg_i,
   output logic          mdu_ready_o,
   input  reg_info_t     mdu_issue_i,
   input  reg_info_t     r1_info_i,
   input  reg_info_t     r2_info_i,
   output reg_t          wreg_o,
   output logic [31:0]   busy_o,
   output logic          stall_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   reg_t           head;
   logic [31:0]    busy_q;
   logic [31:0]    busy_d;
   logic [CW-1:0]  starve_cnt;
   logic           starve;
   logic           r1_hit;
   logic           r2_hit;

   // Results to r0 complete the handshake but are never stored.
   assign mdu_ready_o = !fifo_full;
   assign push        = mdu_wreg_i.en && mdu_ready_o && (mdu_wreg_i.addr != 5'd0);
   assign pop         = !pipe_wreg_i.en && !fifo_empty;

   regwrite_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (mdu_wreg_i),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   // Write-port select: pipeline first, then buffer head, else idle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      wreg_o = '0;
      if (pipe_wreg_i.en)  wreg_o = pipe_wreg_i;
      else if (!fifo_empty) wreg_o = head;
   end

   // Reservation next state: clear on pop, then set so a same-cycle issue wins.
   always_comb begin
      busy_d = busy_q;
      if (pop) busy_d[head.addr] = 1'b0;
      if (mdu_issue_i.en && (mdu_issue_i.addr != 5'd0)) busy_d[mdu_issue_i.addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Reservation register.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) busy_q <= '0;
      else                   busy_q <= busy_d;
   end

   // Starve counter: counts waiting cycles of a non-empty, unpopped buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         starve_cnt <= '0;
      end else if (fifo_empty || pop) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

   assign starve = (starve_cnt == CW'(STARVE_LIMIT));

   // Read hazard detection against reservations.
   always_comb begin
      r1_hit = r1_info_i.en && busy_q[r1_info_i.addr];
      r2_hit = r2_info_i.en && busy_q[r2_info_i.addr];
`ifdef REGWRITE_BYPASS_EN
      if (pop && (r1_info_i.addr == head.addr)) r1_hit = 1'b0;
      if (pop && (r2_info_i.addr == head.addr)) r2_hit = 1'b0;
`endif
   end

   assign stall_o = r1_hit || r2_hit || starve;
   assign busy_o  = busy_q;

endmodule
